// File: rtl/pid_controller.sv
// Registered PID controller: saturating integral (anti-windup), first-difference
// derivative and a full-precision sum clamped to the output width.
module pid_controller #(
  parameter int WIDTH = 16,
  parameter int KP    = 1,
  parameter int KI    = 1,
  parameter int KD    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] setpoint,
  input  logic signed [WIDTH-1:0] feedback,
  output logic signed [WIDTH-1:0] control_out
);

  localparam int UW = 2*WIDTH + 4;

  localparam logic signed [UW-1:0] KP_W = UW'(KP);
  localparam logic signed [UW-1:0] KI_W = UW'(KI);
  localparam logic signed [UW-1:0] KD_W = UW'(KD);

  // Output-range limits, sign-extended to the width they are compared at
  localparam logic signed [WIDTH+1:0] IMAX = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH+1:0] IMIN = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic signed [UW-1:0]    UMAX = {{(UW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [UW-1:0]    UMIN = {{(UW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] integ, integ_nxt, u_sat;
  logic signed [WIDTH:0]   err, prev_e;
  logic signed [WIDTH+1:0] isum, deriv;
  logic signed [UW-1:0]    u;

  always_comb begin
    err   = (WIDTH+1)'(setpoint) - (WIDTH+1)'(feedback);
    isum  = (WIDTH+2)'(integ) + (WIDTH+2)'(err);
    deriv = (WIDTH+2)'(err) - (WIDTH+2)'(prev_e);

    if (isum > IMAX)      integ_nxt = IMAX[WIDTH-1:0];
    else if (isum < IMIN) integ_nxt = IMIN[WIDTH-1:0];
    else                  integ_nxt = isum[WIDTH-1:0];

    // Operands widened first so no product or partial sum can overflow
    u = KP_W * UW'(err) + KI_W * UW'(integ_nxt) + KD_W * UW'(deriv);

    if (u > UMAX)      u_sat = UMAX[WIDTH-1:0];
    else if (u < UMIN) u_sat = UMIN[WIDTH-1:0];
    else               u_sat = u[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      integ       <= '0;
      prev_e      <= '0;
      control_out <= '0;
    end else begin
      integ       <= integ_nxt;
      prev_e      <= err;
      control_out <= u_sat;
    end
  end

endmodule

// File: tb/tb_pid_controller.sv
// Scoreboard bench: default 16-bit DUT on directed steps, plus an 8-bit DUT with
// non-unit gains on random inputs, both checked against a longint reference model.
module tb_pid_controller;

  logic clk = 1'b0;
  logic reset;
  logic signed [15:0] sp_a, fb_a, out_a;
  logic signed [7:0]  sp_b, fb_b, out_b;

  always #5 clk = ~clk;

  pid_controller dut_a (
    .clk(clk), .reset(reset), .setpoint(sp_a), .feedback(fb_a), .control_out(out_a)
  );

  pid_controller #(.WIDTH(8), .KP(3), .KI(-2), .KD(5)) dut_b (
    .clk(clk), .reset(reset), .setpoint(sp_b), .feedback(fb_b), .control_out(out_b)
  );

  typedef struct {
    logic signed [15:0] a;
    logic signed [7:0]  b;
    string              tag;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint ia = 0, pa = 0, ib = 0, pb = 0;

  function automatic longint clampw(input longint v, input int w);
    longint mx, mn;
    mx = (longint'(1) << (w-1)) - 1;
    mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  function automatic longint calc(input bit rst, input longint sp, input longint fb,
                                  input longint kp, input longint ki, input longint kd,
                                  input int w, inout longint i, inout longint p);
    longint e, d;
    if (!rst) begin
      i = 0; p = 0;
      return 0;
    end
    e = sp - fb;
    i = clampw(i + e, w);
    d = e - p;
    p = e;
    return clampw(kp*e + ki*i + kd*d, w);
  endfunction

  task automatic cmp(input string tag);
    exp_t x;
    x = sb.pop_front();
    checks++;
    assert (out_a === x.a) else begin
      errors++;
      $error("FAIL %s: control_out=%0d expected=%0d", x.tag, out_a, x.a);
    end
    checks++;
    assert (out_b === x.b) else begin
      errors++;
      $error("FAIL %s_gain8: control_out=%0d expected=%0d", tag, out_b, x.b);
    end
  endtask

  // One clock edge: drive, push expectation, sample 1 time unit after the edge.
  // use_k selects a spec constant for DUT A; otherwise the model value is used.
  task automatic step(input bit rst, input int sp, input int fb,
                      input bit use_k, input int k, input string tag);
    exp_t   x;
    longint ua, ub;
    int     s2, f2;
    s2 = $urandom_range(255) - 128;
    f2 = $urandom_range(255) - 128;
    reset = rst;
    sp_a = 16'(sp); fb_a = 16'(fb);
    sp_b = 8'(s2);  fb_b = 8'(f2);
    ua = calc(rst, sp, fb, 1, 1, 1, 16, ia, pa);
    ub = calc(rst, s2, f2, 3, -2, 5, 8, ib, pb);
    x.a = use_k ? 16'(k) : 16'(ua);
    x.b = 8'(ub);
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    cmp(tag);
  endtask

  initial begin
    reset = 1'b0;
    sp_a = '0; fb_a = '0; sp_b = '0; fb_b = '0;
    @(negedge clk);

    for (int n = 0; n < 3; n++) step(0, 100, 0, 1, 0, "reset_hold");

    step(1, 100, 0,  1, 300, "step_e100");
    step(1, 100, 5,  1, 285, "step_e95");
    step(1, 100, 10, 1, 370, "step_e90");

    // Output holds between edges
    @(negedge clk);
    checks++;
    assert (out_a === 16'sd370) else begin
      errors++;
      $error("FAIL hold_between_edges: control_out=%0d expected=370", out_a);
    end
    @(posedge clk); #1;
    sb.push_back('{a: out_a, b: out_b, tag: "dummy"});
    void'(sb.pop_back());
    // Re-align model with the extra edge (inputs unchanged: e=90, I=375, D=0 -> 465)
    void'(calc(1, 100, 10, 1, 1, 1, 16, ia, pa));
    ib = 0; pb = 0;
    checks++;
    assert (out_a === 16'sd465) else begin
      errors++;
      $error("FAIL extra_edge: control_out=%0d expected=465", out_a);
    end
    @(negedge clk);

    step(0, 100, 10, 1, 0,   "reset_mid");
    step(1, 100, 0,  1, 300, "restart_e100");

    step(0, 0, 0, 1, 0, "reset");
    for (int n = 0; n < 5; n++) step(1, 50, 50, 1, 0, "zero_error");

    step(0, 0, 0, 1, 0, "reset");
    for (int n = 0; n < 3; n++) step(1, 32767, -32768, 1, 32767, "pos_sat");

    step(0, 0, 0, 1, 0, "reset");
    step(1, -32768, 32767, 1, -32768, "neg_sat");
    step(1, -32768, 32767, 1, -32768, "neg_sat_hold");
    step(1, 0, 0, 1, 32767,  "neg_recover_d");
    step(1, 0, 0, 1, -32768, "neg_recover_i");
    step(1, 0, 0, 1, -32768, "neg_recover_i2");

    step(0, 0, 0, 1, 0, "reset");
    for (int n = 0; n < 60; n++) begin
      int s, f;
      s = int'($urandom_range(65535)) - 32768;
      f = int'($urandom_range(65535)) - 32768;
      if (n % 4 != 0) begin
        s = s / 64;
        f = f / 64;
      end
      step((n % 23) != 22, s, f, 0, 0, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
